// File: rtl/falling_edge_event_source.sv
// falling_edge_event_source
//   Source side of a falling-edge event crossing. Each accepted srcpulse is
//   delivered as one high-then-low excursion of srcdata. The destination
//   echoes its resynchronized level back on dstack, which closes a
//   four-phase handshake. Events that arrive while a handshake is in flight
//   are queued in a saturating counter.
//
// Ports
//   srcclk    in   source clock (rising edge)
//   srcreset  in   asynchronous active-high reset
//   srcpulse  in   event request, one event per cycle high
//   dstack    in   level echoed from the destination (asynchronous)
//   srcdata   out  registered handshake level
//   busy      out  handshake in flight or events queued
//   pending   out  queued events not yet started
//   overflow  out  one-cycle pulse when an event is dropped
//   timeout   out  one-cycle pulse when a handshake is aborted
module falling_edge_event_source #(
    parameter int CNT_WIDTH = 4,
    parameter int TIMEOUT   = 0,
    parameter int TO_WIDTH  = 16
) (
    input  logic                 srcclk,
    input  logic                 srcreset,
    input  logic                 srcpulse,
    input  logic                 dstack,
    output logic                 srcdata,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pending,
    output logic                 overflow,
    output logic                 timeout
);

    typedef enum logic [1:0] {IDLE, RISE, FALL} state_t;

    localparam logic [CNT_WIDTH-1:0] PEND_MAX = '1;
    localparam bit                   TO_EN    = (TIMEOUT > 0);
    // Abort on the edge where the cycle count in RISE/FALL reaches TIMEOUT.
    localparam logic [TO_WIDTH-1:0]  TO_LAST  = TO_EN ? TO_WIDTH'(TIMEOUT - 1) : '0;

    state_t                state, state_nxt;
    logic                  ack_s1, ack_s2;
    logic                  srcdata_nxt, overflow_nxt, timeout_nxt;
    logic [CNT_WIDTH-1:0]  pending_nxt;
    logic [TO_WIDTH-1:0]   to_cnt, to_cnt_nxt;
    logic                  take, inc, dec, expired;

    always_ff @(posedge srcclk or posedge srcreset) begin
        if (srcreset) begin
            state    <= IDLE;
            ack_s1   <= 1'b0;
            ack_s2   <= 1'b0;
            srcdata  <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
            timeout  <= 1'b0;
            to_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            ack_s1   <= dstack;
            ack_s2   <= ack_s1;
            srcdata  <= srcdata_nxt;
            pending  <= pending_nxt;
            overflow <= overflow_nxt;
            timeout  <= timeout_nxt;
            to_cnt   <= to_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        srcdata_nxt  = srcdata;
        overflow_nxt = 1'b0;
        timeout_nxt  = 1'b0;
        take         = 1'b0;
        expired      = TO_EN && (to_cnt == TO_LAST);

        case (state)
            IDLE: begin
                // ack_s2 is deliberately ignored here.
                if (srcpulse || (pending != '0)) begin
                    state_nxt   = RISE;
                    srcdata_nxt = 1'b1;
                    take        = 1'b1;
                end
            end
            RISE: begin
                // A real acknowledge wins over a same-cycle expiry.
                if (ack_s2) begin
                    state_nxt   = FALL;
                    srcdata_nxt = 1'b0;
                end else if (expired) begin
                    state_nxt   = IDLE;
                    srcdata_nxt = 1'b0;
                    timeout_nxt = 1'b1;
                end
            end
            FALL: begin
                if (!ack_s2) begin
                    state_nxt = IDLE;
                end else if (expired) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                srcdata_nxt = 1'b0;
            end
        endcase

        // The queue head is served first; a fresh pulse is consumed directly
        // only when nothing is queued.
        dec = take && (pending != '0);
        inc = srcpulse && !(take && (pending == '0));

        pending_nxt = pending;
        if (inc && !dec) begin
            if (pending == PEND_MAX) overflow_nxt = 1'b1;
            else                     pending_nxt  = pending + 1'b1;
        end else if (dec && !inc) begin
            pending_nxt = pending - 1'b1;
        end

        if (!TO_EN || (state_nxt != state) || (state == IDLE))
            to_cnt_nxt = '0;
        else
            to_cnt_nxt = to_cnt + 1'b1;
    end

    assign busy = (state != IDLE) || (pending != '0);

endmodule
